// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline enable/bubble/flush control with pending-flush FSM,
//            halt handling and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_stall_dec,
    input  logic             ld_stall_exe,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_bubble,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] c_RUN        = 2'd0;
    localparam logic [1:0] c_FLUSH_PEND = 2'd1;
    localparam logic [1:0] c_HALTED     = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic             w_brAccept;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Outputs: priority chain HALTED > dmem > ld_exe > branch > ld_dec > imem
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_en     = 1'b1;
        halted       = 1'b0;
        w_brAccept   = 1'b0;

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (r_state == c_HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
        end else begin
            if (dmem_stall) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (ld_stall_exe) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
            end else if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                w_brAccept  = 1'b1;
            end else if (ld_stall_dec) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else if (imem_stall) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            // The word in flight belongs to the squashed path until fetch recovers
            if (r_state == c_FLUSH_PEND && ifid_en) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_RUN: begin
                if (w_brAccept && imem_stall) begin
                    w_nextState = c_FLUSH_PEND;
                end
            end
            c_FLUSH_PEND: begin
                if (!(w_brAccept && imem_stall) && !imem_stall && !dmem_stall) begin
                    w_nextState = c_RUN;
                end
            end
            c_HALTED: w_nextState = c_HALTED;
            default:  w_nextState = c_RUN;
        endcase
        if (r_state != c_HALTED && !dmem_stall && halt_wb) begin
            w_nextState = c_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_RUN;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state != c_HALTED && !pc_en && r_stallCnt != c_CNT_MAX) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_brAccept && r_flushCnt != c_CNT_MAX) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst, ld_stall_dec, ld_stall_exe, br_taken, imem_stall, dmem_stall, halt_wb;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic exmem_en, exmem_bubble, memwb_en, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic sPc, sIfid, sIfidFl, sIdex, sIdexB, sExmem, sExmemB, sMemwb, sHalted;
    logic [1:0] sStall, sFlush;

    pipe_stall_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ld_stall_dec(ld_stall_dec), .ld_stall_exe(ld_stall_exe),
        .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .exmem_bubble(exmem_bubble),
        .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_ctrl #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .ld_stall_dec(ld_stall_dec), .ld_stall_exe(ld_stall_exe),
        .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_wb(halt_wb),
        .pc_en(sPc), .ifid_en(sIfid), .ifid_flush(sIfidFl), .idex_en(sIdex),
        .idex_bubble(sIdexB), .exmem_en(sExmem), .exmem_bubble(sExmemB),
        .memwb_en(sMemwb), .halted(sHalted), .stall_cnt(sStall), .flush_cnt(sFlush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs packed {rst, ld_dec, ld_exe, br, imem, dmem, halt}
    // Outputs packed {pc, ifid, ifidFlush, idex, idexBub, exmem, exmemBub, memwb, halted}
    logic [8:0] actO, actSatO;
    assign actO    = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
                      exmem_en, exmem_bubble, memwb_en, halted};
    assign actSatO = {sPc, sIfid, sIfidFl, sIdex, sIdexB, sExmem, sExmemB, sMemwb, sHalted};

    int errors = 0;
    int checks = 0;

    bit mHalted, mPend;
    int mStall, mFlush, mStallSat, mFlushSat;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] modelOut(input logic [6:0] v);
        logic pc, fi, fl, id, ib, ex, eb, mw;
        if (v[6]) return 9'b0;
        if (mHalted) return 9'b000000001;
        {pc, fi, fl, id, ib, ex, eb, mw} = 8'b11010101;
        if (v[1]) {pc, fi, id, ex, mw} = 5'b0;
        else if (v[4]) begin pc = 0; fi = 0; id = 0; eb = 1; end
        else if (v[3]) begin fl = 1; ib = 1; end
        else if (v[5]) begin pc = 0; fi = 0; ib = 1; end
        else if (v[2]) begin pc = 0; fl = 1; end
        if (mPend && fi) fl = 1;
        return {pc, fi, fl, id, ib, ex, eb, mw, 1'b0};
    endfunction

    task automatic modelEdge(input logic [6:0] v, input logic [8:0] o);
        bit brOk;
        if (v[6]) begin
            mHalted = 0; mPend = 0;
            mStall = 0; mFlush = 0; mStallSat = 0; mFlushSat = 0;
            return;
        end
        if (mHalted) return;
        brOk = !v[1] && !v[4] && v[3];
        if (!o[8]) begin
            if (mStall < 65535) mStall++;
            if (mStallSat < 3) mStallSat++;
        end
        if (brOk) begin
            if (mFlush < 65535) mFlush++;
            if (mFlushSat < 3) mFlushSat++;
        end
        if (v[0] && !v[1]) begin
            mHalted = 1; mPend = 0;
        end else if (brOk && v[2]) begin
            mPend = 1;
        end else if (mPend && !v[2] && !v[1]) begin
            mPend = 0;
        end
    endtask

    task automatic cycle(input logic [6:0] v, output logic [8:0] seen);
        logic [8:0] expO;
        {rst, ld_stall_dec, ld_stall_exe, br_taken, imem_stall, dmem_stall, halt_wb} = v;
        #1;
        expO = modelOut(v);
        seen = actO;
        check("outputs", int'(actO), int'(expO));
        check("outputs_w2", int'(actSatO), int'(expO));
        @(posedge clk);
        modelEdge(v, expO);
        #1;
        check("stall_cnt", int'(stall_cnt), mStall);
        check("flush_cnt", int'(flush_cnt), mFlush);
        check("stall_cnt_w2", int'(sStall), mStallSat);
        check("flush_cnt_w2", int'(sFlush), mFlushSat);
    endtask

    typedef struct {
        string      name;
        logic [6:0] in;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[11];
    logic [8:0] seen;
    logic [6:0] rv;

    initial begin
        vecs[0]  = '{"quiet",          7'b0000000, 9'b110101010};
        vecs[1]  = '{"ld_dec",         7'b0100000, 9'b000111010};
        vecs[2]  = '{"ld_exe",         7'b0010000, 9'b000001110};
        vecs[3]  = '{"br",             7'b0001000, 9'b111111010};
        vecs[4]  = '{"br_ld_dec",      7'b0101000, 9'b111111010};
        vecs[5]  = '{"br_ld_exe",      7'b0011000, 9'b000001110};
        vecs[6]  = '{"imem",           7'b0000100, 9'b011101010};
        vecs[7]  = '{"ld_dec_imem",    7'b0100100, 9'b000111010};
        vecs[8]  = '{"dmem",           7'b0000010, 9'b000000000};
        vecs[9]  = '{"dmem_br_ld_exe", 7'b0011010, 9'b000000000};
        vecs[10] = '{"dmem_halt",      7'b0000011, 9'b000000000};

        // Reset, then quiet defaults
        cycle(7'b1000000, seen);
        check("reset_outputs", int'(seen), 0);
        cycle(7'b1000000, seen);
        cycle(7'b0000000, seen);
        check("quiet_after_reset", int'(seen), 9'h1AA);
        check("stall_cnt_reset", int'(stall_cnt), 0);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].in, seen);
            check(vecs[i].name, int'(seen), int'(vecs[i].exp));
        end

        // Single decode stall counts one cycle
        cycle(7'b1000000, seen);
        cycle(7'b0100000, seen);
        check("ld_dec_stall_cnt", int'(stall_cnt), 1);
        cycle(7'b0011000, seen);
        check("br_ld_exe_flush_cnt", int'(flush_cnt), 0);

        // Branch during fetch miss -> pending flush for the whole miss
        cycle(7'b1000000, seen);
        cycle(7'b0001100, seen);
        check("pend_flush_0", int'(seen[6]), 1);
        for (int i = 1; i <= 3; i++) begin
            cycle(7'b0000100, seen);
            check("pend_flush_hold", int'(seen[6]), 1);
        end
        cycle(7'b0000000, seen);
        check("pend_flush_exit", int'(seen), 9'h1EA);
        cycle(7'b0000000, seen);
        check("pend_back_to_run", int'(seen), 9'h1AA);
        check("pend_flush_cnt", int'(flush_cnt), 1);
        check("pend_stall_cnt", int'(stall_cnt), 3);

        // Data memory freeze ignores branch and halt, then halt lands
        cycle(7'b1000000, seen);
        for (int i = 0; i < 5; i++) begin
            cycle(7'b0001011, seen);
            check("dmem_freeze", int'(seen), 0);
        end
        check("dmem_stall_cnt", int'(stall_cnt), 5);
        check("dmem_flush_cnt", int'(flush_cnt), 0);
        cycle(7'b0000001, seen);
        check("halt_cycle_normal", int'(seen), 9'h1AA);
        cycle(7'b0000000, seen);
        check("halted_state", int'(seen), 1);
        cycle(7'b0001100, seen);
        check("halted_stall_cnt", int'(stall_cnt), 5);
        cycle(7'b1000000, seen);
        cycle(7'b0000000, seen);
        check("reset_from_halted", int'(seen), 9'h1AA);

        // Narrow counter saturates
        cycle(7'b1000000, seen);
        for (int i = 0; i < 6; i++) cycle(7'b0000100, seen);
        check("sat_stall_cnt", int'(sStall), 3);
        check("wide_stall_cnt", int'(stall_cnt), 6);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            rv[6] = ($urandom_range(0, 99) < 4);
            rv[5] = ($urandom_range(0, 99) < 25);
            rv[4] = ($urandom_range(0, 99) < 20);
            rv[3] = ($urandom_range(0, 99) < 30);
            rv[2] = ($urandom_range(0, 99) < 35);
            rv[1] = ($urandom_range(0, 99) < 20);
            rv[0] = ($urandom_range(0, 99) < 4);
            cycle(rv, seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
